// File: rtl/hex_count_display.sv
// ---------------------------------------------------------------------------
// hex_count_display
//
// Counts rising edges of the slow divided-clock level coming from the clock
// divider and shows the count as NUM_DIGITS hex digits on a time-multiplexed
// seven-segment display.
//
// Parameters
//   NUM_DIGITS      number of hex digits counted and displayed (1..8)
//   SCAN_DIV        clk_in cycles each digit stays lit (>= 2)
//   SEG_ACTIVE_LOW  1: a 0 on seg_out lights a segment
//   DIG_ACTIVE_LOW  1: a 0 on dig_sel enables a digit
//
// Ports
//   clk_in      system clock
//   rst         synchronous active-high reset, overrides every other input
//   tick_in     divided-clock level, already in the clk_in domain
//   en          count enable; edges seen while low are dropped, not deferred
//   up_dn       1 = count up, 0 = count down (sampled with the edge)
//   count_out   current count, modulo 2^(4*NUM_DIGITS)
//   wrap_pulse  one-cycle pulse alongside a count that wrapped either way
//   seg_out     segments {g,f,e,d,c,b,a}, a is bit 0
//   dig_sel     one digit enable per digit, bit 0 = least-significant digit
// ---------------------------------------------------------------------------
module hex_count_display #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 12000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    tick_in,
    input  logic                    en,
    input  logic                    up_dn,
    output logic [4*NUM_DIGITS-1:0] count_out,
    output logic                    wrap_pulse,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel
);

    localparam int CW     = 4 * NUM_DIGITS;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SCAN_W-1:0]     SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF   = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    // Active-high hex font, bit 0 = segment a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic              tick_prev;
    logic              rise;
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        nibble;
    logic [NUM_DIGITS-1:0] dig_onehot;

    assign rise = tick_in & ~tick_prev;

    // -----------------------------------------------------------------------
    // Edge detect and counter
    // -----------------------------------------------------------------------
    // NOTE: state is written with non-blocking assignments so every register
    // in this block samples the pre-edge value of every other register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            // Loading tick_in here means a level that is already high when
            // reset releases is not mistaken for a fresh edge.
            tick_prev  <= tick_in;
            count_out  <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            tick_prev  <= tick_in;
            wrap_pulse <= 1'b0;
            if (rise && en) begin
                if (up_dn) begin
                    count_out  <= count_out + CW'(1);
                    wrap_pulse <= &count_out;
                end else begin
                    count_out  <= count_out - CW'(1);
                    wrap_pulse <= ~|count_out;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Digit scan: free-running, independent of en
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Digit select and nibble mux for the current index
    // -----------------------------------------------------------------------
    // NOTE: both outputs get a default before the loop, so no path through
    // this block leaves them unassigned and no latch is inferred.
    always_comb begin
        nibble     = '0;
        dig_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nibble        = count_out[4*i +: 4];
                dig_onehot[i] = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered display outputs. dig_sel and seg_out come from the same idx
    // sample, so a digit never briefly shows its neighbour's segments.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            dig_sel <= DIG_OFF;
            seg_out <= SEG_OFF;
        end else begin
            dig_sel <= DIG_ACTIVE_LOW ? ~dig_onehot : dig_onehot;
            seg_out <= SEG_ACTIVE_LOW ? ~hex_to_seg(nibble) : hex_to_seg(nibble);
        end
    end

endmodule

// File: doc/hex_count_display.md
Name: hex_count_display

Overview:
- Consumes the slow divided-clock level produced by the clock divider stage (toggling square wave, clk_in domain).
- Counts rising edges of that level as a NUM_DIGITS-digit hexadecimal value.
- Drives a time-multiplexed common-anode/cathode seven-segment display.
- Sits directly downstream of the divider and upstream of the board pins.

Parameters:
- NUM_DIGITS, 4, number of hex digits counted and displayed (1..8).
- SCAN_DIV, 12000, clk_in cycles each digit is held on the display (1 kHz per digit at 12 MHz); minimum 2.
- SEG_ACTIVE_LOW, 1, 1 = seg_out bits inverted (0 lights a segment).
- DIG_ACTIVE_LOW, 1, 1 = dig_sel bits inverted (0 enables a digit).

Ports:
- clk_in, input, 1, system clock (12 MHz).
- rst, input, 1, synchronous active-high reset.
- tick_in, input, 1, divided-clock level from the divider; registered in clk_in domain, no synchroniser needed.
- en, input, 1, count enable; when 0, edges are ignored.
- up_dn, input, 1, 1 = count up, 0 = count down.
- count_out, output, 4*NUM_DIGITS, current count value.
- wrap_pulse, output, 1, one-cycle pulse on a count wrap.
- seg_out, output, 7, segments {g,f,e,d,c,b,a}; a is bit 0.
- dig_sel, output, NUM_DIGITS, one-hot digit enable; bit 0 is the least-significant digit.

Behaviour:
- All state updates on posedge clk_in. rst has priority over every other input.
- Reset values:
  - count_out = 0, wrap_pulse = 0.
  - scan counter = 0, digit index = 0.
  - dig_sel all inactive; seg_out all segments off.
  - edge register tick_prev loads tick_in during reset, so tick_in held high across reset release produces no count.
- Edge detect:
  - rise = tick_in & ~tick_prev; tick_prev <= tick_in every cycle.
  - Falling edges are ignored.
  - One count per tick_in period (about 0.96 s with the default divider).
- Count:
  - On rise & en, count_out updates at that same posedge, i.e. 1-cycle latency from the first cycle tick_in is sampled high.
  - up_dn is sampled in that same cycle.
  - Arithmetic is modulo 2^(4*NUM_DIGITS).
  - Up from all-F gives 0; down from 0 gives all-F. wrap_pulse = 1 for exactly the cycle following either wrap, else 0.
  - rise with en = 0: count_out unchanged, wrap_pulse = 0, and the edge is not deferred.
- Scan:
  - The scan counter runs 0..SCAN_DIV-1 continuously, independent of en.
  - At the terminal value it returns to 0 and the digit index advances 0,1,..,NUM_DIGITS-1,0.
- Display outputs (registered):
  - Each cycle, dig_sel <= one-hot(index) and seg_out <= decode(count_out nibble[index]), both from the same index value, so they change together with no ghost cycle.
  - Polarity per SEG_ACTIVE_LOW / DIG_ACTIVE_LOW.
  - A count change shows on the active digit within 1 cycle.
- Decode (active-high, hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Reset mid-operation:
  - Any state returns to reset values on the next posedge.
  - The first valid dig_sel/seg_out appears 1 cycle after rst deasserts, showing digit 0 = "0".

Test Plan:
1. rst = 1 with tick_in = 1 for 3 cycles, release, hold tick_in = 1 for 10 cycles -> count_out stays 0x0000, wrap_pulse never asserted. Then tick_in 0->1 -> count_out = 0x0001 one cycle later.
2. en = 1, up_dn = 1, five tick_in rising edges (each high 3 cycles, low 3 cycles) -> count_out = 0x0005. Falling edges cause no change; each increment lands exactly one cycle after the rising edge.
3. From 0x0000, up_dn = 0, one edge -> count_out = 0xFFFF with wrap_pulse high for exactly 1 cycle. Then up_dn = 1, one edge -> 0x0000 with wrap_pulse high for 1 cycle.
4. count_out = 0x0003, en = 0, four edges -> count_out stays 0x0003. en = 1, one edge -> 0x0004 (disabled edges are not replayed).
5. SCAN_DIV = 4, defaults otherwise, count_out = 0x1A2F -> dig_sel (active-low) cycles E,D,B,7 every 4 cycles. seg_out = ~0x71, ~0x5B, ~0x77, ~0x06 aligned with each digit; sequence repeats.
6. SCAN_DIV = 4, assert rst while digit 2 is active and count_out = 0x00FF -> next cycle: dig_sel = 0xF, seg_out = 0x7F, count_out = 0. One cycle after release: dig_sel = 0xE, seg_out = ~0x3F.
